// File: rtl/dds_spi_config_ctrl.sv
// Serial configuration controller for a DDS: arbitrates frequency and phase
// word writes round-robin and shifts the granted word out MSB first with a chip select.
module dds_spi_config_ctrl #(
    parameter int unsigned FREQ_WIDTH  = 16,
    parameter int unsigned PHASE_WIDTH = 8,
    parameter int unsigned CLK_DIV     = 4
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   freq_valid,
    input  logic [FREQ_WIDTH-1:0]  freq_word,
    output logic                   freq_ready,
    input  logic                   phase_valid,
    input  logic [PHASE_WIDTH-1:0] phase_word,
    output logic                   phase_ready,
    output logic                   spi_clk,
    output logic                   spi_data,
    output logic                   freq_cs,
    output logic                   phaseshift_cs,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned MAX_W       = (FREQ_WIDTH > PHASE_WIDTH) ? FREQ_WIDTH : PHASE_WIDTH;
    localparam int unsigned BIT_W       = $clog2(MAX_W + 1);
    localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FREQ_SHIFT  = MAX_W - FREQ_WIDTH;
    localparam int unsigned PHASE_SHIFT = MAX_W - PHASE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] FREQ_BITS  = BIT_W'(FREQ_WIDTH);
    localparam logic [BIT_W-1:0] PHASE_BITS = BIT_W'(PHASE_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bits;
    logic [MAX_W-1:0]   r_shift;
    logic               r_last_phase;
    logic               r_spi_clk;
    logic               r_spi_data;
    logic               r_freq_cs;
    logic               r_phase_cs;
    logic               r_busy;
    logic               r_done;

    logic               w_idle;
    logic               w_grant_freq;
    logic               w_grant_phase;
    logic               w_handshake;
    logic               w_div_end;
    logic [MAX_W-1:0]   w_load_word;
    logic [MAX_W-1:0]   w_shift_next;

    // Round-robin: on contention the requester not served last wins.
    assign w_grant_freq  = freq_valid  && (!phase_valid || r_last_phase);
    assign w_grant_phase = phase_valid && (!freq_valid  || !r_last_phase);
    assign w_idle        = (r_state == S_IDLE) && !rst;
    assign freq_ready    = w_idle && w_grant_freq;
    assign phase_ready   = w_idle && w_grant_phase;
    assign w_handshake   = freq_ready || phase_ready;
    assign w_div_end     = (r_div == DIV_LAST);

    // Words are left-aligned so the shifter MSB is always the next bit and zeros follow bit 0.
    assign w_load_word  = w_grant_freq ? (MAX_W'(freq_word) << FREQ_SHIFT)
                                       : (MAX_W'(phase_word) << PHASE_SHIFT);
    assign w_shift_next = r_shift << 1;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bits       <= '0;
            r_shift      <= '0;
            r_last_phase <= 1'b1;
            r_spi_clk    <= 1'b0;
            r_spi_data   <= 1'b0;
            r_freq_cs    <= 1'b0;
            r_phase_cs   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_div <= w_div_end ? '0 : r_div + DIV_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (w_handshake) begin
                        r_state      <= S_SETUP;
                        r_shift      <= w_load_word;
                        r_bits       <= w_grant_freq ? FREQ_BITS : PHASE_BITS;
                        r_last_phase <= !w_grant_freq;
                        r_spi_data   <= w_load_word[MAX_W-1];
                        r_freq_cs    <= w_grant_freq;
                        r_phase_cs   <= !w_grant_freq;
                        r_busy       <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_state   <= S_HIGH;
                        r_spi_clk <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_div_end) begin
                        r_state    <= S_LOW;
                        r_spi_clk  <= 1'b0;
                        r_shift    <= w_shift_next;
                        r_spi_data <= w_shift_next[MAX_W-1];
                        r_bits     <= r_bits - BIT_W'(1);
                    end
                end
                S_LOW: begin
                    if (w_div_end) begin
                        if (r_bits == '0) begin
                            r_state    <= S_GAP;
                            r_freq_cs  <= 1'b0;
                            r_phase_cs <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state   <= S_HIGH;
                            r_spi_clk <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_clk       = r_spi_clk;
    assign spi_data      = r_spi_data;
    assign freq_cs       = r_freq_cs;
    assign phaseshift_cs = r_phase_cs;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: doc/dds_spi_config_ctrl.md
DDS_SPI_CONFIG_CTRL -- requirements
Module: dds_spi_config_ctrl

Interface
REQ-001 SHALL have parameter FREQ_WIDTH, default 16, meaning the bit count of a frequency word (equals the DDS accumulator length).
REQ-002 SHALL have parameter PHASE_WIDTH, default 8, meaning the bit count of a phase-shift word.
REQ-003 SHALL have parameter CLK_DIV, default 4, range >= 1, meaning sys_clk cycles per spi_clk half-period.
REQ-004 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port freq_valid  input  1  frequency-word write request.
REQ-007 SHALL have port freq_word  input  FREQ_WIDTH  frequency word, sampled at handshake.
REQ-008 SHALL have port freq_ready  output  1  frequency request accepted this cycle when freq_valid is also high.
REQ-009 SHALL have port phase_valid  input  1  phase-shift write request.
REQ-010 SHALL have port phase_word  input  PHASE_WIDTH  phase word, sampled at handshake.
REQ-011 SHALL have port phase_ready  output  1  phase request accepted this cycle when phase_valid is also high.
REQ-012 SHALL have port spi_clk  output  1  serial clock to DDS; DDS samples spi_data on its rising edge.
REQ-013 SHALL have port spi_data  output  1  serial data, MSB first.
REQ-014 SHALL have port freq_cs  output  1  frequency chip select, active-high; falling edge loads the word into the DDS.
REQ-015 SHALL have port phaseshift_cs  output  1  phase chip select, same semantics as freq_cs.
REQ-016 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-017 SHALL have port done  output  1  one-cycle pulse on completion of a transfer.

Function
REQ-018 SHALL implement states IDLE, SETUP, HIGH, LOW, GAP.
REQ-019 SHALL drive a ready output high only in IDLE, and only toward the requester granted by REQ-020.
REQ-020 SHALL arbitrate round-robin:
- With one valid, grant that requester.
- With both valid, grant the requester not served last.
- The last-served pointer resets to "phase", so freq wins first.
REQ-021 SHALL, on handshake at cycle T, capture the word, the target select and N (the word width), then enter SETUP at T+1.
REQ-022 SHALL, in SETUP, assert the selected cs, hold spi_clk=0 and spi_data=word[N-1], for CLK_DIV cycles.
REQ-023 SHALL, in HIGH, drive spi_clk=1 for CLK_DIV cycles with spi_data stable.
REQ-024 SHALL, in LOW, drive spi_clk=0 for CLK_DIV cycles, with spi_data updated to the next lower bit on the first LOW cycle.
- After bit 0, spi_data SHALL be 0.
REQ-025 SHALL run exactly N HIGH/LOW pairs, then enter GAP.
REQ-026 SHALL, in GAP, deassert cs for CLK_DIV cycles, then return to IDLE.
- done SHALL pulse on the first GAP cycle.
REQ-027 SHALL give a total busy duration of CLK_DIV*(2N+2) cycles and a cs-high duration of CLK_DIV*(2N+1) cycles.
REQ-028 SHALL never assert freq_cs and phaseshift_cs simultaneously, and never toggle the unselected cs.
REQ-029 SHALL ignore word and valid changes during a transfer; pending requests wait, and the first grant occurs in the cycle IDLE is re-entered.
REQ-030 SHALL use a bit counter wide enough for max(FREQ_WIDTH, PHASE_WIDTH) and a half-period counter wide enough for CLK_DIV, with no wrap within a transfer.

Reset
REQ-031 SHALL, while rst is high, force the following on the next edge regardless of state:
- state=IDLE.
- spi_clk, spi_data, freq_cs, phaseshift_cs, busy, done, freq_ready, phase_ready = 0.
- round-robin pointer = phase.
REQ-032 SHALL abort any transfer in progress on reset, without completing GAP or pulsing done.
REQ-033 SHALL accept requests from the first cycle after rst deasserts.

Verification (FREQ_WIDTH=16, PHASE_WIDTH=8, CLK_DIV=2)
REQ-034 SHALL cover freq write 0xA5C3:
- 16 spi_clk rising edges sample 1010010111000011.
- freq_cs high 66 cycles; busy 68 cycles; one done pulse.
- phaseshift_cs stays 0.
REQ-035 SHALL cover phase write 0x81:
- 8 edges sample 10000001.
- phaseshift_cs high 34 cycles; busy 36 cycles.
REQ-036 SHALL cover freq and phase valid together after reset:
- freq granted first, phase second.
- Repeated simultaneous requests alternate freq/phase.
REQ-037 SHALL cover rst asserted mid-transfer on the 5th HIGH phase:
- All outputs 0 next cycle; no done pulse.
- A new request 1 cycle after rst deasserts is accepted.
REQ-038 SHALL cover freq_word changed during a transfer: the serialized bits equal the word captured at handshake.
REQ-039 SHALL cover CLK_DIV=1 with freq write 0xFFFF: spi_clk toggles every cycle and busy lasts 34 cycles.
